// File: rtl/thread_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : thread_pc_unit_if
// Description : Decode/ALU-side bundle for the per-thread PC and NZP unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface thread_pc_unit_if #(
  parameter int PC_BITS   = 8,
  parameter int DATA_BITS = 8
) ();
  logic                 enable;
  logic [2:0]           core_state;
  logic [2:0]           decoded_nzp;
  logic [PC_BITS-1:0]   decoded_immediate;
  logic                 decoded_nzp_write_enable;
  logic                 decoded_pc_mux;
  logic                 decoded_call;
  logic                 decoded_ret;
  logic [DATA_BITS-1:0] alu_out;
  logic [PC_BITS-1:0]   current_pc;
  logic [PC_BITS-1:0]   next_pc;
  logic [2:0]           nzp;
  logic                 ras_overflow;
  logic                 ras_underflow;

  modport master (
    output enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_call,
           decoded_ret, alu_out, current_pc,
    input  next_pc, nzp, ras_overflow, ras_underflow
  );

  modport slave (
    input  enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_call,
           decoded_ret, alu_out, current_pc,
    output next_pc, nzp, ras_overflow, ras_underflow
  );
endinterface
`default_nettype wire

// File: rtl/thread_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : thread_pc_unit
// Description : Per-thread next-PC resolution and NZP flag latch. Optional
//               return-address stack built when PC_RAS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_pc_unit #(
  parameter int PC_BITS   = 8,
  parameter int DATA_BITS = 8,
  parameter int RAS_DEPTH = 4
) (
  input  wire              clk,
  input  wire              reset,
  thread_pc_unit_if.slave  bus
);
  localparam logic [2:0]         C_ST_EXECUTE = 3'b101;
  localparam logic [2:0]         C_ST_UPDATE  = 3'b110;
  localparam logic [PC_BITS-1:0] C_PC_ONE     = PC_BITS'(1);

  logic [PC_BITS-1:0] next_pc_q, next_pc_d;
  logic [2:0]         nzp_q, nzp_d;
  logic [PC_BITS-1:0] w_pc_inc;
  logic [PC_BITS-1:0] w_branch_pc;
  logic               w_exec;
  logic               w_update;

  assign w_pc_inc    = bus.current_pc + C_PC_ONE;
  assign w_exec      = bus.enable && (bus.core_state == C_ST_EXECUTE);
  assign w_update    = bus.enable && (bus.core_state == C_ST_UPDATE)
                       && bus.decoded_nzp_write_enable;
  // Flags are the ones latched by an earlier UPDATE; no bypass is needed.
  assign w_branch_pc = (bus.decoded_pc_mux && ((nzp_q & bus.decoded_nzp) != 3'b000))
                       ? bus.decoded_immediate : w_pc_inc;

  always_comb begin
    nzp_d = nzp_q;
    if (w_update) nzp_d = bus.alu_out[2:0];
  end

`ifdef PC_RAS_EN
  localparam int                    C_PTR_BITS = $clog2(RAS_DEPTH) + 1;
  localparam logic [C_PTR_BITS-1:0] C_FULL     = C_PTR_BITS'(RAS_DEPTH);
  localparam logic [C_PTR_BITS-1:0] C_PTR_ONE  = C_PTR_BITS'(1);

  logic [PC_BITS-1:0]    ras_mem_q [RAS_DEPTH];
  logic [C_PTR_BITS-1:0] sp_q, sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  w_push;
  logic [C_PTR_BITS-2:0] w_top_idx;
  logic                  w_unused;

  assign w_top_idx = sp_q[C_PTR_BITS-2:0] - 1'b1;
  assign w_unused  = &{1'b0, bus.alu_out};

  always_comb begin
    next_pc_d = next_pc_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    w_push    = 1'b0;
    if (w_exec) begin
      if (bus.decoded_call && bus.decoded_ret) begin
        next_pc_d = w_pc_inc;
      end else if (bus.decoded_ret) begin
        if (sp_q != '0) begin
          next_pc_d = ras_mem_q[w_top_idx];
          sp_d      = sp_q - C_PTR_ONE;
        end else begin
          next_pc_d = w_pc_inc;
          unf_d     = 1'b1;
        end
      end else if (bus.decoded_call) begin
        // A call on a full stack still jumps; only the return address is lost.
        next_pc_d = bus.decoded_immediate;
        if (sp_q != C_FULL) begin
          w_push = 1'b1;
          sp_d   = sp_q + C_PTR_ONE;
        end else begin
          ovf_d  = 1'b1;
        end
      end else begin
        next_pc_d = w_branch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) ras_mem_q[sp_q[C_PTR_BITS-2:0]] <= w_pc_inc;
  end

  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.alu_out, bus.decoded_call, bus.decoded_ret};

  always_comb begin
    next_pc_d = next_pc_q;
    if (w_exec) next_pc_d = w_branch_pc;
  end

  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      nzp_q     <= 3'b000;
    end else begin
      next_pc_q <= next_pc_d;
      nzp_q     <= nzp_d;
    end
  end

  assign bus.next_pc = next_pc_q;
  assign bus.nzp     = nzp_q;
endmodule
`default_nettype wire
